// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 32-bit combinational ALU: a command FIFO feeds the ALU
// from storage only, and each ALU result is captured into a valid/ready output slot.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_x,
  input  logic [31:0]              in_y,
  input  logic [2:0]               in_op,
  output logic [31:0]              alu_x,
  output logic [31:0]              alu_y,
  output logic [2:0]               alu_op,
  input  logic [31:0]              alu_z,
  input  logic                     alu_zero,
  input  logic                     alu_equal,
  input  logic                     alu_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_z,
  output logic                     out_zero,
  output logic                     out_equal,
  output logic                     out_overflow,
  output logic [2:0]               out_op,
  output logic                     out_reserved,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         issued
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL    = LW'(DEPTH);
  localparam logic [2:0]    OP_RSVD = 3'b111;

  logic [31:0]    x_mem  [DEPTH];
  logic [31:0]    y_mem  [DEPTH];
  logic [2:0]     op_mem [DEPTH];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  count_q, count_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic           out_valid_q, out_valid_d;
  logic [31:0]    out_z_q, out_z_d;
  logic           out_zero_q, out_zero_d;
  logic           out_equal_q, out_equal_d;
  logic           out_overflow_q, out_overflow_d;
  logic [2:0]     out_op_q, out_op_d;
  logic           out_reserved_q, out_reserved_d;

  logic           empty_s, push_s, cap_s;
  logic [31:0]    head_x_s, head_y_s;
  logic [2:0]     head_op_s;

  // Handshake qualifiers; a full FIFO never accepts, even on a same-cycle pop.
  always_comb begin
    empty_s   = (count_q == {LW{1'b0}});
    in_ready  = (count_q != FULL);
    push_s    = in_valid && in_ready;
    cap_s     = !empty_s && (!out_valid_q || out_ready);
    head_x_s  = x_mem[rd_ptr_q];
    head_y_s  = y_mem[rd_ptr_q];
    head_op_s = op_mem[rd_ptr_q];
  end

  // ALU is fed only from storage; an empty FIFO idles it on the reserved opcode.
  always_comb begin
    if (empty_s) begin
      alu_x  = 32'h0000_0000;
      alu_y  = 32'h0000_0000;
      alu_op = OP_RSVD;
    end else begin
      alu_x  = head_x_s;
      alu_y  = head_y_s;
      alu_op = head_op_s;
    end
  end

  // Pointer, occupancy and result-slot next state.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    issued_d       = issued_q;
    out_valid_d    = out_valid_q;
    out_z_d        = out_z_q;
    out_zero_d     = out_zero_q;
    out_equal_d    = out_equal_q;
    out_overflow_d = out_overflow_q;
    out_op_d       = out_op_q;
    out_reserved_d = out_reserved_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, cap_s})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase

    if (cap_s) begin
      rd_ptr_d       = rd_ptr_q + AW'(1);
      issued_d       = issued_q + CNT_W'(1);
      out_valid_d    = 1'b1;
      out_z_d        = alu_z;
      out_zero_d     = alu_zero;
      out_equal_d    = alu_equal;
      out_overflow_d = alu_overflow;
      out_op_d       = head_op_s;
      out_reserved_d = (head_op_s == OP_RSVD);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      x_mem[wr_ptr_q]  <= in_x;
      y_mem[wr_ptr_q]  <= in_y;
      op_mem[wr_ptr_q] <= in_op;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      count_q        <= {LW{1'b0}};
      issued_q       <= {CNT_W{1'b0}};
      out_valid_q    <= 1'b0;
      out_z_q        <= 32'h0000_0000;
      out_zero_q     <= 1'b0;
      out_equal_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_op_q       <= 3'b000;
      out_reserved_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      issued_q       <= issued_d;
      out_valid_q    <= out_valid_d;
      out_z_q        <= out_z_d;
      out_zero_q     <= out_zero_d;
      out_equal_q    <= out_equal_d;
      out_overflow_q <= out_overflow_d;
      out_op_q       <= out_op_d;
      out_reserved_q <= out_reserved_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_z        = out_z_q;
  assign out_zero     = out_zero_q;
  assign out_equal    = out_equal_q;
  assign out_overflow = out_overflow_q;
  assign out_op       = out_op_q;
  assign out_reserved = out_reserved_q;
  assign level        = count_q;
  assign issued       = issued_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU model on the alu_* side.
module tb_alu_issue_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_x, in_y;
  logic [2:0]  in_op;
  logic [31:0] alu_x, alu_y, alu_z;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_equal, alu_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_z;
  logic        out_zero, out_equal, out_overflow, out_reserved;
  logic [2:0]  out_op;
  logic [2:0]  level;
  logic [3:0]  issued;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_issued;

  alu_issue_stage #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_op(in_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_z(alu_z), .alu_zero(alu_zero), .alu_equal(alu_equal), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_zero(out_zero), .out_equal(out_equal), .out_overflow(out_overflow),
    .out_op(out_op), .out_reserved(out_reserved),
    .level(level), .issued(issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: reserved opcode yields zero result with all flags low.
  always_comb begin
    case (alu_op)
      3'b000:  alu_z = alu_x & alu_y;
      3'b001:  alu_z = alu_x + alu_y;
      3'b010:  alu_z = alu_x - alu_y;
      3'b011:  alu_z = {31'd0, ($signed(alu_x) < $signed(alu_y))};
      3'b100:  alu_z = alu_x >> alu_y[4:0];
      3'b101:  alu_z = $unsigned($signed(alu_x) >>> alu_y[4:0]);
      3'b110:  alu_z = alu_x << alu_y[4:0];
      default: alu_z = 32'd0;
    endcase
    alu_zero     = (alu_op != 3'b111) && (alu_z == 32'd0);
    alu_equal    = (alu_op != 3'b111) && (alu_x == alu_y);
    alu_overflow = ((alu_op == 3'b001) && (alu_x[31] == alu_y[31]) && (alu_z[31] != alu_x[31])) ||
                   ((alu_op == 3'b010) && (alu_x[31] != alu_y[31]) && (alu_z[31] != alu_x[31]));
  end

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  op;
    logic [31:0] z;
    logic [2:0]  flags;   // {zero, equal, overflow}
    logic        rsvd;
  } vec_t;

  vec_t vecs [10];
  logic [31:0] stream_z [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    in_op    = op;
  endtask

  initial begin
    int acc;
    vecs[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 3'b001, 32'h8000_0000, 3'b001, 1'b0};
    vecs[1] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 3'b000, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h0000_0005, 3'b010, 32'h0000_0000, 3'b110, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 3'b011, 32'h0000_0001, 3'b000, 1'b0};
    vecs[4] = '{32'h0000_0001, 32'h0000_001F, 3'b110, 32'h8000_0000, 3'b000, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0024, 3'b100, 32'h0800_0000, 3'b000, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h0000_0004, 3'b101, 32'hF800_0000, 3'b000, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h0000_0001, 3'b010, 32'h7FFF_FFFF, 3'b001, 1'b0};
    vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000, 3'b000, 1'b1};
    vecs[9] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b001, 32'h0000_0000, 3'b100, 1'b0};
    stream_z[0] = 32'h0F0F_0000;
    stream_z[1] = 32'h0000_0000;
    stream_z[2] = 32'h0000_0001;
    stream_z[3] = 32'h8000_0000;

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    exp_issued = 4'd0;
    #12 rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd7);
    check("rst_alu_x", alu_x, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_op", {29'd0, out_op}, 32'd0);
    check("rst_issued", {28'd0, issued}, 32'd0);
    @(negedge clk);

    // Single commands: head presented after the push edge, result one edge later.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].op);
      tick();
      in_valid = 1'b0;
      check("vec_head_level", {29'd0, level}, 32'd1);
      check("vec_alu_y", alu_y, vecs[i].y);
      check("vec_alu_op", {29'd0, alu_op}, {29'd0, vecs[i].op});
      check("vec_early_valid", {31'd0, out_valid}, 32'd0);
      tick();
      exp_issued = exp_issued + 4'd1;
      check("vec_out_valid", {31'd0, out_valid}, 32'd1);
      check("vec_out_z", out_z, vecs[i].z);
      check("vec_flags", {29'd0, out_zero, out_equal, out_overflow}, {29'd0, vecs[i].flags});
      check("vec_out_op", {29'd0, out_op}, {29'd0, vecs[i].op});
      check("vec_reserved", {31'd0, out_reserved}, {31'd0, vecs[i].rsvd});
      check("vec_issued", {28'd0, issued}, {28'd0, exp_issued});
    end

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b000);
        1:       drive(1'b1, 32'd5, 32'd5, 3'b010);
        2:       drive(1'b1, 32'hFFFF_FFFF, 32'd0, 3'b011);
        3:       drive(1'b1, 32'd1, 32'd31, 3'b110);
        default: drive(1'b0, 32'd0, 32'd0, 3'b000);
      endcase
      tick();
      if (i >= 1) begin
        exp_issued = exp_issued + 4'd1;
        check("stream_valid", {31'd0, out_valid}, 32'd1);
        check("stream_z", out_z, stream_z[i-1]);
        check("stream_issued", {28'd0, issued}, {28'd0, exp_issued});
        if (i == 2) check("stream_zero_eq", {30'd0, out_zero, out_equal}, 32'd3);
      end
    end
    check("stream_level_end", {29'd0, level}, 32'd0);
    tick();
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Stalled consumer: one command in the slot plus DEPTH in the FIFO.
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'(k), 32'd100, 3'b001);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    exp_issued = exp_issued + 4'd1;
    check("full_accepted", 32'(acc), 32'd5);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_level", {29'd0, level}, 32'd4);
    tick();
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_z", out_z, 32'd100);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      exp_issued = exp_issued + 4'd1;
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      check("drain_z", out_z, 32'd100 + 32'(k));
      if (k == 1) check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    end
    check("drain_issued", {28'd0, issued}, {28'd0, exp_issued});
    tick();
    check("drain_done", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-cycle with three commands queued.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111);
      else        drive(1'b1, 32'(k), 32'd1, 3'b001);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_level", {29'd0, level}, 32'd3);
    check("pre_rst_reserved", {31'd0, out_reserved}, 32'd1);
    #3 rst = 1'b1;
    #1;
    exp_issued = 4'd0;
    check("arst_level", {29'd0, level}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_reserved", {31'd0, out_reserved}, 32'd0);
    check("arst_out_op", {29'd0, out_op}, 32'd0);
    check("arst_issued", {28'd0, issued}, 32'd0);
    check("arst_alu_op", {29'd0, alu_op}, 32'd7);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    #2 rst = 1'b0;
    tick();
    check("post_rst_level", {29'd0, level}, 32'd0);

    // Counter wrap: 17 captures from reset on a 4-bit counter.
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 32'(k), 32'd2, 3'b001);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("wrap_issued", {28'd0, issued}, 32'd1);
    check("wrap_last_z", out_z, 32'd18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
